// File: rtl/fifo_rd_packer.sv
// Read-domain drain stage for the async byte FIFO: pops show-ahead bytes, packs
// LANES of them into a keep-masked word and presents it on a valid/ready port.
module fifo_rd_packer #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned LANES   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                    rclk,
    input  logic                    rst,
    input  logic                    empty,
    input  logic [DATA_W-1:0]       rdata,
    output logic                    rinc,
    output logic [DATA_W*LANES-1:0] m_data,
    output logic [LANES-1:0]        m_keep,
    output logic                    m_valid,
    input  logic                    m_ready
);

    localparam int unsigned CNT_W  = $clog2(LANES + 1);
    localparam int unsigned IDLE_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(LANES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT);
    localparam logic              FLUSH_EN  = (TIMEOUT != 0);

    logic [LANES-1:0][DATA_W-1:0] r_lanes;
    logic [CNT_W-1:0]             r_cnt;
    logic [IDLE_W-1:0]            r_idle;
    logic [LANES-1:0][DATA_W-1:0] r_data;
    logic [LANES-1:0]             r_keep;
    logic                         r_valid;

    logic                         w_out_free;
    logic                         w_pop;
    logic                         w_full;
    logic                         w_flush;
    logic [LANES-1:0][DATA_W-1:0] w_full_word;
    logic [LANES-1:0][DATA_W-1:0] w_flush_word;
    logic [LANES-1:0]             w_flush_keep;

    // Pop/transfer decisions; a pop always beats a pending flush.
    always_comb begin
        w_out_free = !r_valid || m_ready;
        w_pop      = !rst && !empty && ((r_cnt < LAST_LANE) || w_out_free);
        w_full     = w_pop && (r_cnt == LAST_LANE);
        w_flush    = FLUSH_EN && !w_pop && (r_cnt != '0) &&
                     (r_idle == IDLE_MAX) && w_out_free;
    end

    // Word images: the full word takes its last lane straight from the FIFO head.
    always_comb begin
        w_full_word            = r_lanes;
        w_full_word[LANES-1]   = rdata;
        w_flush_keep           = '0;
        w_flush_word           = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            w_flush_keep[i] = (CNT_W'(i) < r_cnt);
            w_flush_word[i] = w_flush_keep[i] ? r_lanes[i] : '0;
        end
    end

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_lanes <= '0;
            r_cnt   <= '0;
            r_idle  <= '0;
            r_data  <= '0;
            r_keep  <= '0;
            r_valid <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (w_pop && (r_cnt == CNT_W'(i))) begin
                    r_lanes[i] <= rdata;
                end
            end

            if (w_full) begin
                r_data  <= w_full_word;
                r_keep  <= '1;
                r_valid <= 1'b1;
                r_cnt   <= '0;
            end else if (w_flush) begin
                r_data  <= w_flush_word;
                r_keep  <= w_flush_keep;
                r_valid <= 1'b1;
                r_cnt   <= '0;
            end else begin
                if (w_pop) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                if (r_valid && m_ready) begin
                    r_valid <= 1'b0;
                end
            end

            // Idle counts only while a partial word waits with nothing to pop.
            if (w_pop || w_flush) begin
                r_idle <= '0;
            end else if ((r_cnt != '0) && (r_idle != IDLE_MAX)) begin
                r_idle <= r_idle + IDLE_W'(1);
            end
        end
    end

    assign rinc    = w_pop;
    assign m_data  = r_data;
    assign m_keep  = r_keep;
    assign m_valid = r_valid;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: directed scenarios plus a random phase, checked
// against a queue-based packing model and a byte-order scoreboard.
module tb_fifo_rd_packer;

    localparam int LANES = 4;
    localparam int TO    = 16;

    typedef logic [7:0] byte_t;

    logic        clk;
    logic        rst;
    logic        empty,   empty0;
    logic [7:0]  rdata,   rdata0;
    logic        rinc,    rinc0;
    logic [31:0] m_data,  m_data0;
    logic [3:0]  m_keep,  m_keep0;
    logic        m_valid, m_valid0;
    logic        m_ready, m_ready0;

    fifo_rd_packer #(.DATA_W(8), .LANES(4), .TIMEOUT(16)) dut (
        .rclk(clk), .rst(rst), .empty(empty), .rdata(rdata), .rinc(rinc),
        .m_data(m_data), .m_keep(m_keep), .m_valid(m_valid), .m_ready(m_ready)
    );

    fifo_rd_packer #(.DATA_W(8), .LANES(4), .TIMEOUT(0)) dut0 (
        .rclk(clk), .rst(rst), .empty(empty0), .rdata(rdata0), .rinc(rinc0),
        .m_data(m_data0), .m_keep(m_keep0), .m_valid(m_valid0), .m_ready(m_ready0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          total, bad;
    int          tick_no, last_pop, pops, pops0;
    byte_t       fifo_q[$], q0[$], sb[$], acc[$];
    logic [31:0] rx_d[$];
    logic [3:0]  rx_k[$];
    logic [31:0] rinc_hist;
    int          idle;
    logic        ev;
    logic [31:0] ed;
    logic [3:0]  ek;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input byte_t b);
        fifo_q.push_back(b);
        sb.push_back(b);
    endtask

    // Every accepted lane must be the next byte that entered the FIFO.
    task automatic accept(input logic [31:0] d, input logic [3:0] k);
        rx_d.push_back(d);
        rx_k.push_back(k);
        chk("keep_shape", 64'((k != 4'd0) && ((k & (k + 4'd1)) == 4'd0)), 64'd1);
        for (int i = 0; i < 4; i++) begin
            if (k[i]) begin
                chk("sb_avail", 64'(sb.size() > 0), 64'd1);
                if (sb.size() > 0) chk("sb_byte", 64'(d[8*i +: 8]), 64'(sb.pop_front()));
            end
        end
    endtask

    task automatic load_word();
        logic [31:0] w;
        w = 32'd0;
        for (int i = 0; i < acc.size(); i++) w = w | (32'(acc[i]) << (8 * i));
        ed   = w;
        ek   = 4'((1 << acc.size()) - 1);
        ev   = 1'b1;
        idle = 0;
        acc.delete();
    endtask

    // One clock: starts and ends at a falling edge.
    task automatic tick();
        logic xr, free, pr, pr0;
        empty  = (fifo_q.size() == 0);
        rdata  = empty ? 8'h00 : fifo_q[0];
        empty0 = (q0.size() == 0);
        rdata0 = empty0 ? 8'h00 : q0[0];
        #1;
        free = !ev || m_ready;
        xr   = !rst && !empty && ((acc.size() < LANES - 1) || free);
        chk("rinc", 64'(rinc), 64'(xr));
        chk("rinc0_empty", 64'(rinc0 && empty0), 64'd0);
        pr = rinc;
        pr0 = rinc0;
        rinc_hist = {rinc_hist[30:0], pr};
        if (!rst && m_valid && m_ready) accept(m_data, m_keep);
        @(posedge clk);
        #1;
        tick_no++;
        if (rst) begin
            acc.delete(); idle = 0; ev = 1'b0; ed = 32'd0; ek = 4'd0;
        end else begin
            if (xr) acc.push_back(rdata);
            if (xr && acc.size() == LANES) load_word();
            else if (!xr && acc.size() != 0 && idle == TO && free) load_word();
            else begin
                if (ev && m_ready) ev = 1'b0;
                if (xr) idle = 0;
                else if (acc.size() != 0 && idle < TO) idle++;
            end
        end
        if (pr && fifo_q.size() > 0) begin
            void'(fifo_q.pop_front());
            last_pop = tick_no;
            pops++;
        end
        if (pr0 && q0.size() > 0) begin
            void'(q0.pop_front());
            pops0++;
        end
        chk("m_valid", 64'(m_valid), 64'(ev));
        chk("m_data", 64'(m_data), 64'(ed));
        chk("m_keep", 64'(m_keep), 64'(ek));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_rinc", 64'(rinc), 64'd0);
        chk("rst_valid", 64'(m_valid), 64'd0);
        chk("rst_data", 64'(m_data), 64'd0);
        chk("rst_keep", 64'(m_keep), 64'd0);
        chk("rst_valid0", 64'(m_valid0), 64'd0);
        acc.delete(); idle = 0; ev = 1'b0; ed = 32'd0; ek = 4'd0;
        sb = fifo_q;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_valid(input string tag, input int n);
        for (int i = 0; i < n && !m_valid; i++) tick();
        chk(tag, 64'(m_valid), 64'd1);
    endtask

    initial begin
        int p_push, p_ready;
        total = 0; bad = 0; tick_no = 0; last_pop = 0; pops = 0; pops0 = 0;
        rinc_hist = 32'd0; idle = 0; ev = 1'b0; ed = 32'd0; ek = 4'd0;
        rst = 1'b0; empty = 1'b1; empty0 = 1'b1; rdata = 8'h00; rdata0 = 8'h00;
        m_ready = 1'b0; m_ready0 = 1'b1;
        @(negedge clk);
        do_reset();

        // Streaming at full rate
        m_ready = 1'b1;
        for (int k = 1; k <= 8; k++) push(8'(17 * k));
        rx_d.delete(); rx_k.delete(); pops = 0;
        repeat (10) tick();
        chk("t1_pops", 64'(pops), 64'd8);
        chk("t1_rinc_run", 64'(rinc_hist[9:0]), 64'b1111111100);
        chk("t1_nwords", 64'(rx_d.size()), 64'd2);
        chk("t1_w0", 64'(rx_d[0]), 64'h44332211);
        chk("t1_w1", 64'(rx_d[1]), 64'h88776655);
        chk("t1_k0", 64'(rx_k[0]), 64'hF);
        chk("t1_k1", 64'(rx_k[1]), 64'hF);

        // Backpressure
        m_ready = 1'b0; pops = 0; rx_d.delete(); rx_k.delete();
        for (int k = 0; k < 12; k++) push(8'(8'h21 + k));
        repeat (20) tick();
        chk("t2_pops", 64'(pops), 64'd7);
        chk("t2_rinc_stop", 64'(rinc), 64'd0);
        chk("t2_held_valid", 64'(m_valid), 64'd1);
        chk("t2_held_data", 64'(m_data), 64'h24232221);
        m_ready = 1'b1;
        repeat (20) tick();
        chk("t2_nwords", 64'(rx_d.size()), 64'd3);
        chk("t2_w0", 64'(rx_d[0]), 64'h24232221);
        chk("t2_w1", 64'(rx_d[1]), 64'h28272625);
        chk("t2_w2", 64'(rx_d[2]), 64'h2C2B2A29);

        // Timeout flush of a 3-byte partial word
        do_reset();
        m_ready = 1'b1;
        push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (3) tick();
        wait_valid("t3_flush_seen", 40);
        // idle reaches TIMEOUT after TO idle edges; the flush lands on the next one
        chk("t3_delay", 64'(tick_no - last_pop), 64'(TO + 1));
        chk("t3_data", 64'(m_data), 64'h00A3A2A1);
        chk("t3_keep", 64'(m_keep), 64'b0111);

        // A byte arriving as idle hits TIMEOUT is packed instead of flushing
        tick(); tick();
        push(8'hB1); push(8'hB2); push(8'hB3);
        repeat (3) tick();
        repeat (TO) tick();
        push(8'hB4);
        tick();
        chk("t4_pop_wins", 64'(last_pop), 64'(tick_no));
        chk("t4_valid", 64'(m_valid), 64'd1);
        chk("t4_keep", 64'(m_keep), 64'hF);
        chk("t4_data", 64'(m_data), 64'hB4B3B2B1);
        tick();
        push(8'hB5);
        tick();
        wait_valid("t4_flush_seen", 40);
        chk("t4_idle_restart", 64'(tick_no - last_pop), 64'(TO + 1));
        chk("t4_flush_keep", 64'(m_keep), 64'b0001);
        chk("t4_flush_data", 64'(m_data), 64'h000000B5);

        // Reset with a held word and two bytes accumulated
        tick();
        m_ready = 1'b0;
        for (int k = 0; k < 6; k++) push(8'(8'h31 + k));
        repeat (6) tick();
        chk("t5_pre_valid", 64'(m_valid), 64'd1);
        chk("t5_all_popped", 64'(fifo_q.size()), 64'd0);
        do_reset();
        m_ready = 1'b1; rx_d.delete(); rx_k.delete();
        for (int k = 0; k < 4; k++) push(8'(8'h41 + k));
        wait_valid("t5_word_seen", 10);
        chk("t5_data", 64'(m_data), 64'h44434241);
        chk("t5_keep", 64'(m_keep), 64'hF);
        tick();
        chk("t5_nwords", 64'(rx_d.size()), 64'd1);

        // Random traffic with varying fill and ready rates
        p_push = 50; p_ready = 50;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (cyc % 150 == 0) begin
                p_push  = int'($urandom_range(0, 100));
                p_ready = int'($urandom_range(10, 100));
            end
            if (cyc == 700) do_reset();
            if (int'($urandom_range(0, 99)) < p_push && fifo_q.size() < 32)
                push(8'($urandom));
            m_ready = (int'($urandom_range(0, 99)) < p_ready);
            tick();
        end
        m_ready = 1'b1;
        repeat (80) tick();
        chk("rand_fifo_drained", 64'(fifo_q.size()), 64'd0);
        chk("rand_sb_drained", 64'(sb.size()), 64'd0);
        chk("rand_idle_valid", 64'(m_valid), 64'd0);

        // TIMEOUT=0 instance never flushes partials
        pops0 = 0;
        q0.push_back(8'hD1); q0.push_back(8'hD2); q0.push_back(8'hD3);
        repeat (3) tick();
        chk("t6_pops", 64'(pops0), 64'd3);
        for (int i = 0; i < 100; i++) begin
            tick();
            chk("t6_no_word", 64'(m_valid0), 64'd0);
        end
        q0.push_back(8'hD4);
        tick();
        chk("t6_valid", 64'(m_valid0), 64'd1);
        chk("t6_data", 64'(m_data0), 64'hD4D3D2D1);
        chk("t6_keep", 64'(m_keep0), 64'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
